// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared select codes, register-index constants and the pipeline tracking-entry type
// for the hazard/forwarding controller.
package hazard_forward_ctrl_pkg;

  localparam int RA_W = 5;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_REG = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;

  localparam logic [RA_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            regwrite;
    logic            memread;
  } trk_entry_t;

  localparam trk_entry_t TRK_BUBBLE = '0;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage decode bundle in, EX forwarding selects and stall/flush out.
// master = pipeline side driving decode info, slave = hazard controller.
interface hazard_forward_ctrl_if #(
  parameter int REG_ADDR_W = hazard_forward_ctrl_pkg::RA_W
);
  logic                  hold;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  branch_taken;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  stall;
  logic                  flush;

  modport master (
    output hold, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_memread, branch_taken,
    input  fwd_a, fwd_b, stall, flush
  );

  modport slave (
    input  hold, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_memread, branch_taken,
    output fwd_a, fwd_b, stall, flush
  );
endinterface

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Pure compare of one source register against the EX and MEM producers; zero latency.
// Newest producer (EX) wins; x0 and unused sources always select the register file.
module fwd_select
  import hazard_forward_ctrl_pkg::*;
(
  input  logic [RA_W-1:0] i_rs,
  input  logic            i_used,
  input  trk_entry_t      i_ex_e,
  input  trk_entry_t      i_mem_e,
  output fwd_sel_t        o_sel
);

  always_comb begin
    o_sel = FWD_REG;
    if (i_used && (i_rs != REG_ZERO)) begin
      if (i_ex_e.valid && i_ex_e.regwrite && (i_ex_e.rd == i_rs)) begin
        o_sel = FWD_MEM;
      end else if (i_mem_e.valid && i_mem_e.regwrite && (i_mem_e.rd == i_rs)) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard controller: ID-cycle compare registered into EX selects (1 cycle); stall/flush are
// combinational. hold freezes all state and masks stall/flush. HAZARD_STATS_EN adds counters.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = RA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_forward_ctrl_if.slave  bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count
`endif
);

  if (REG_ADDR_W != RA_W) begin : g_width_check
    $error("REG_ADDR_W must match hazard_forward_ctrl_pkg::RA_W");
  end

  trk_entry_t r_ex_e;
  trk_entry_t r_mem_e;
  trk_entry_t r_wb_e;
  fwd_sel_t   r_fwd_a;
  fwd_sel_t   r_fwd_b;

  trk_entry_t w_id_e;
  fwd_sel_t   w_sel_a;
  fwd_sel_t   w_sel_b;
  logic       w_load_use;
  logic       w_bubble;

  always_comb begin
    w_id_e          = TRK_BUBBLE;
    w_id_e.valid    = bus.id_valid;
    w_id_e.rd       = bus.id_rd;
    w_id_e.regwrite = bus.id_regwrite;
    w_id_e.memread  = bus.id_memread;
  end

  // A taken branch kills the consumer anyway, so it suppresses the load-use stall.
  assign w_load_use = bus.id_valid & r_ex_e.valid & r_ex_e.memread & (r_ex_e.rd != REG_ZERO)
                    & ((bus.id_rs1_used & (bus.id_rs1 == r_ex_e.rd))
                     | (bus.id_rs2_used & (bus.id_rs2 == r_ex_e.rd)))
                    & ~bus.branch_taken;

  assign w_bubble = w_load_use | bus.branch_taken | ~bus.id_valid;

  fwd_select u_fwd_a (
    .i_rs    (bus.id_rs1),
    .i_used  (bus.id_rs1_used),
    .i_ex_e  (r_ex_e),
    .i_mem_e (r_mem_e),
    .o_sel   (w_sel_a)
  );

  fwd_select u_fwd_b (
    .i_rs    (bus.id_rs2),
    .i_used  (bus.id_rs2_used),
    .i_ex_e  (r_ex_e),
    .i_mem_e (r_mem_e),
    .o_sel   (w_sel_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_e  <= TRK_BUBBLE;
      r_mem_e <= TRK_BUBBLE;
      r_wb_e  <= TRK_BUBBLE;
      r_fwd_a <= FWD_REG;
      r_fwd_b <= FWD_REG;
    end else if (!bus.hold) begin
      r_wb_e  <= r_mem_e;
      r_mem_e <= r_ex_e;
      r_ex_e  <= w_bubble ? TRK_BUBBLE : w_id_e;
      r_fwd_a <= w_bubble ? FWD_REG : w_sel_a;
      r_fwd_b <= w_bubble ? FWD_REG : w_sel_b;
    end
  end

  assign bus.fwd_a = r_fwd_a;
  assign bus.fwd_b = r_fwd_b;
  assign bus.stall = w_load_use & ~bus.hold;
  assign bus.flush = bus.branch_taken & ~bus.hold;

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.flush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;
`endif

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Pipeline hazard controller that generates the 2-bit select codes consumed by the EX-stage ALU-operand 3-input forwarding multiplexers.
- Tracks the destination register of the instructions in EX, MEM and WB internally.
- Issues one-cycle load-use stalls and branch flushes.
- Sits between the ID stage decode outputs and the EX-stage datapath.

Parameters:
- REG_ADDR_W, 5, register index width; register 0 is hardwired zero and is never forwarded.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- hold  input  1  global pipeline freeze (memory wait); freezes all state
- id_valid  input  1  ID stage holds a real instruction
- id_rs1  input  REG_ADDR_W  ID source register A
- id_rs2  input  REG_ADDR_W  ID source register B
- id_rs1_used  input  1  instruction reads rs1
- id_rs2_used  input  1  instruction reads rs2
- id_rd  input  REG_ADDR_W  ID destination register
- id_regwrite  input  1  instruction writes rd
- id_memread  input  1  instruction is a load
- branch_taken  input  1  EX resolved a taken branch this cycle
- fwd_a  output  2  registered select for ALU operand A mux, valid during EX
- fwd_b  output  2  registered select for ALU operand B mux, valid during EX
- stall  output  1  hold PC and IF/ID, insert bubble into ID/EX
- flush  output  1  kill IF/ID contents

Behaviour:
- Select encoding: 00 = register file value; 01 = EX/MEM result; 10 = MEM/WB writeback value; 11 = never driven.
- Internal tracking entries, each {valid, rd, regwrite, memread}: ex_e, mem_e, wb_e.
- On each clock edge with hold=0:
  - wb_e <= mem_e; mem_e <= ex_e.
  - ex_e <= ID entry, or a bubble (valid=0) if stall|branch_taken|!id_valid.
- Forward compare is performed in the ID cycle and registered into fwd_a/fwd_b, so the select is valid when the instruction is in EX. For source rs (with used=1, rs≠0):
  - ex_e.valid & regwrite & rd==rs -> 01.
  - Else mem_e.valid & regwrite & rd==rs -> 10.
  - Else 00.
  - 01 has priority over 10 (newest producer wins).
- Bubble loaded into EX -> fwd_a=fwd_b=00.
- stall is combinational:
  - stall = id_valid & ex_e.valid & ex_e.memread & ex_e.rd≠0 & ((rs1_used & rs1==ex_e.rd) | (rs2_used & rs2==ex_e.rd)) & !branch_taken.
  - Exactly one bubble per load-use. On the next cycle the load is in mem_e and the consumer gets select 10.
- flush = branch_taken (combinational).
- Simultaneous branch_taken and load-use: flush wins, stall=0.
- Writes three instructions ahead are covered by register-file write-before-read; no select is generated for them.
- hold=1: all registers, including fwd_a/fwd_b, keep their values. stall and flush are forced to 0.
- Reset values: all tracking entries invalid; fwd_a=fwd_b=00; stall=0; flush=0. Asserting reset mid-stream discards all in-flight tracking immediately.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, adds two output ports:
  - stall_count [31:0]: increments on each edge where stall=1 and hold=0.
  - flush_count [31:0]: increments on each edge where flush=1 and hold=0.
  - Both reset to 0 and wrap at 2^32.
- When not defined, neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - REG_ZERO=0.
  - The tracking-entry struct/field widths.
- One sub-module: fwd_select, a pure compare producing one 2-bit select from (rs, used, ex_e, mem_e). Instantiated twice, for A and B.

Test Plan:
- add x5 then add x6,x5,x5 back-to-back -> in consumer's EX cycle, fwd_a=01 and fwd_b=01; stall=0.
- add x5, nop, sub x7,x5,x1 -> consumer EX: fwd_a=10, fwd_b=00.
- lw x8 then add x9,x8,x2 -> stall=1 for exactly 1 cycle, bubble EX fwd=00, then consumer EX fwd_a=10.
- Writes to x0 from ALU and from load, followed by a consumer of x0 -> fwd=00, stall never asserted.
- Load-use coincident with branch_taken=1 -> flush=1, stall=0, next ex_e is a bubble; hold=1 for 3 cycles mid-sequence -> fwd/tracking unchanged, then resume with correct selects.
- Async rst pulse between clock edges with valid entries in flight -> outputs 00/0 immediately. With HAZARD_STATS_EN, after 2 stalls and 1 flush: stall_count=2, flush_count=1.
